// File: rtl/galois_add_three_arbiter_if.sv
// Request/result bundle for the shared mod-P three-operand adder.
// master: requesters and result consumer. slave: the arbitrated adder.
interface galois_add_three_arbiter_if #(
  parameter int N_BITS  = 254,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*N_BITS-1:0] req_num1;
  logic [NUM_REQ*N_BITS-1:0] req_num2;
  logic [NUM_REQ*N_BITS-1:0] req_num3;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_BITS-1:0]         out_sum;
  logic [ID_W-1:0]           out_id;
  logic [CNT_W-1:0]          op_count;

  modport master (
    output req_valid, req_num1, req_num2, req_num3, out_ready,
    input  req_ready, out_valid, out_sum, out_id, op_count
  );

  modport slave (
    input  req_valid, req_num1, req_num2, req_num3, out_ready,
    output req_ready, out_valid, out_sum, out_id, op_count
  );
endinterface

// File: rtl/galois_add_three_arbiter.sv
// Round-robin shared (num1+num2+num3) mod PRIME_MODULUS adder with a
// single-entry registered result and a consumed-result counter.
module galois_add_three_arbiter #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int                NUM_REQ       = 4,
  parameter int                CNT_W         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  galois_add_three_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [N_BITS+1:0]        P1     = {2'b00, PRIME_MODULUS};
  localparam logic [N_BITS+1:0]        P2     = {1'b0, PRIME_MODULUS, 1'b0};
  localparam logic signed [N_BITS+1:0] ZERO_S = '0;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t            state_q;
  logic [N_BITS-1:0] sum_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic                 can_accept;
  logic                 found;
  logic [ID_W-1:0]      grant;
  logic [ID_W:0]        cand;
  logic [NUM_REQ-1:0]   ready;
  logic [N_BITS-1:0]    opa, opb, opc;
  logic [N_BITS+1:0]    temp;
  logic signed [N_BITS+1:0] t2, t1;
  logic [N_BITS-1:0]    result;
  logic                 accept;
  logic                 drain;

  assign drain      = (state_q == S_FULL) & bus.out_ready;
  assign can_accept = (state_q == S_EMPTY) | bus.out_ready;

  // Round-robin search from ptr, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
        grant = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  // One-hot accept toward the winner only when the output slot can take it.
  always_comb begin
    ready = '0;
    if (found && can_accept) ready[grant] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign accept        = found & can_accept;

  // Operand mux and conditional-subtract reduction (2P first, then P).
  always_comb begin
    opa    = bus.req_num1[int'(grant)*N_BITS +: N_BITS];
    opb    = bus.req_num2[int'(grant)*N_BITS +: N_BITS];
    opc    = bus.req_num3[int'(grant)*N_BITS +: N_BITS];
    temp   = {2'b00, opa} + {2'b00, opb} + {2'b00, opc};
    t2     = $signed(temp - P2);
    t1     = $signed(temp - P1);
    result = temp[N_BITS-1:0];
    if (t2 >= ZERO_S)      result = t2[N_BITS-1:0];
    else if (t1 >= ZERO_S) result = t1[N_BITS-1:0];
  end

  // Output slot FSM: refill on accept (same-cycle drain allowed), else drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (drain) cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        state_q <= S_FULL;
        sum_q   <= result;
        id_q    <= grant;
        ptr_q   <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
      end else if (drain) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign bus.out_valid = (state_q == S_FULL);
  assign bus.out_sum   = sum_q;
  assign bus.out_id    = id_q;
  assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_galois_add_three_arbiter.sv
// Bench for galois_add_three_arbiter: per-cycle model comparison plus
// directed literal checks, and a narrow-counter instance for wrap.
module tb_galois_add_three_arbiter;
  localparam int N  = 254;
  localparam int NR = 4;
  localparam logic [253:0] PM  = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [253:0] PM1 = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000000;
  localparam logic [253:0] PM3 = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593effffffe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  galois_add_three_arbiter_if #(.N_BITS(N), .NUM_REQ(NR), .CNT_W(32)) bus ();
  galois_add_three_arbiter_if #(.N_BITS(N), .NUM_REQ(NR), .CNT_W(4))  bus6 ();

  galois_add_three_arbiter #(.N_BITS(N), .PRIME_MODULUS(PM), .NUM_REQ(NR), .CNT_W(32))
    dut (.clk(clk), .rst(rst), .bus(bus));
  galois_add_three_arbiter #(.N_BITS(N), .PRIME_MODULUS(PM), .NUM_REQ(NR), .CNT_W(4))
    dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_valid = 1'b0;
  logic [253:0] m_sum   = '0;
  int           m_id    = 0;
  int           m_ptr   = 0;
  logic [31:0]  m_cnt   = '0;
  bit           live    = 1'b0;

  function automatic logic [253:0] mod3(input logic [253:0] a, input logic [253:0] b,
                                        input logic [253:0] c);
    logic [255:0] t;
    t = {2'b00, a} + {2'b00, b} + {2'b00, c};
    return 254'(t % {2'b00, PM});
  endfunction

  function automatic int first_req();
    for (int k = 0; k < NR; k++) begin
      if (bus.req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit acc;
    if (rst) begin
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_id    <= 0;
      m_ptr   <= 0;
      m_cnt   <= '0;
      live    <= 1'b1;
    end else if (live) begin
      g   = first_req();
      acc = (g >= 0) && (!m_valid || bus.out_ready);
      if (m_valid && bus.out_ready) m_cnt <= m_cnt + 1;
      if (acc) begin
        m_valid <= 1'b1;
        m_sum   <= mod3(bus.req_num1[g*N +: N], bus.req_num2[g*N +: N], bus.req_num3[g*N +: N]);
        m_id    <= g;
        m_ptr   <= (g + 1) % NR;
      end else if (m_valid && bus.out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NR-1:0] er;
    int g;
    if (live) begin
      er = '0;
      g  = first_req();
      if (g >= 0 && (!m_valid || bus.out_ready)) er[g] = 1'b1;
      chk("req_ready", 256'(bus.req_ready), 256'(er));
      chk("out_valid", 256'(bus.out_valid), 256'(m_valid));
      chk("op_count", 256'(bus.op_count), 256'(m_cnt));
      if (m_valid) begin
        chk("out_sum", 256'(bus.out_sum), 256'(m_sum));
        chk("out_id", 256'(bus.out_id), 256'(m_id));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [253:0] a,
                         input logic [253:0] b, input logic [253:0] c);
    bus.req_valid[i]      = v;
    bus.req_num1[i*N +: N] = a;
    bus.req_num2[i*N +: N] = b;
    bus.req_num3[i*N +: N] = c;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0);
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_num1   = '0;
    bus.req_num2   = '0;
    bus.req_num3   = '0;
    bus.out_ready  = 1'b1;
    bus6.req_valid = '0;
    bus6.req_num1  = '0;
    bus6.req_num2  = '0;
    bus6.req_num3  = '0;
    bus6.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_sum", 256'(bus.out_sum), 256'd0);
    chk("rst_id", 256'(bus.out_id), 256'd0);
    chk("rst_cnt", 256'(bus.op_count), 256'd0);

    // T1: canonical maximum operands
    set_req(0, 1'b1, PM1, PM1, PM1);
    tick();
    chk("t1_valid", 256'(bus.out_valid), 256'd1);
    chk("t1_id", 256'(bus.out_id), 256'd0);
    chk("t1_sum", 256'(bus.out_sum), 256'(PM3));
    clear_reqs();
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // T2: all requesters, round-robin order
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 254'(i + 1), 254'd2, 254'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_id", 256'(bus.out_id), 256'(k % 4));
      chk("t2_sum", 256'(bus.out_sum), 256'(6 + k % 4));
    end
    clear_reqs();
    tick();
    chk("t2_cnt", 256'(bus.op_count), 256'd5);

    // T3: backpressure holds the result and blocks new grants
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 254'd10, 254'd20, 254'd30);
    tick();
    chk("t3_fill", 256'(bus.out_sum), 256'd60);
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 254'd4, 254'd5, 254'd6);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_sum", 256'(bus.out_sum), 256'd60);
      chk("t3_hold_id", 256'(bus.out_id), 256'd0);
      chk("t3_hold_rdy", 256'(bus.req_ready), 256'd0);
      chk("t3_hold_cnt", 256'(bus.op_count), 256'd5);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_rdy_rise", 256'(bus.req_ready), 256'b0010);
    tick();
    chk("t3_id", 256'(bus.out_id), 256'd1);
    chk("t3_sum", 256'(bus.out_sum), 256'd15);
    chk("t3_cnt", 256'(bus.op_count), 256'd6);
    clear_reqs();
    tick();
    chk("t3_empty", 256'(bus.out_valid), 256'd0);

    // T4: reduction boundaries
    set_req(3, 1'b1, PM1, 254'd1, 254'd0);
    tick();
    chk("t4_p_sum", 256'(bus.out_sum), 256'd0);
    chk("t4_p_id", 256'(bus.out_id), 256'd3);
    set_req(3, 1'b1, PM1, PM1, 254'd2);
    tick();
    chk("t4_2p_sum", 256'(bus.out_sum), 256'd0);
    set_req(3, 1'b1, PM1, PM1, 254'd1);
    tick();
    chk("t4_2pm1_sum", 256'(bus.out_sum), 256'(PM1));
    clear_reqs();
    tick();

    // T5: reset while holding a result
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 254'd1, 254'd1, 254'd1);
    tick();
    chk("t5_full", 256'(bus.out_valid), 256'd1);
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 254'd7, 254'd0, 254'd0);
    set_req(3, 1'b1, 254'd9, 254'd0, 254'd0);
    tick();
    rst = 1'b0;
    chk("t5_valid", 256'(bus.out_valid), 256'd0);
    chk("t5_cnt", 256'(bus.op_count), 256'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("t5_rdy", 256'(bus.req_ready), 256'b0010);
    tick();
    chk("t5_id", 256'(bus.out_id), 256'd1);
    chk("t5_sum", 256'(bus.out_sum), 256'd7);
    clear_reqs();
    tick();

    // T6: 4-bit counter wrap on the narrow instance
    bus6.req_valid[0]   = 1'b1;
    bus6.req_num1[0 +: N] = 254'd1;
    bus6.req_num2[0 +: N] = 254'd2;
    bus6.req_num3[0 +: N] = 254'd3;
    repeat (17) tick();
    chk("t6_cnt16", 256'(bus6.op_count), 256'd0);
    tick();
    chk("t6_cnt17", 256'(bus6.op_count), 256'd1);
    chk("t6_sum", 256'(bus6.out_sum), 256'd6);
    bus6.req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
